// File: rtl/capture_ring_buffer_pkg.sv
// Shared types and helpers for the capture ring buffer: FSM states,
// modulo-ENTRIES pointer increment and the two supported buffer depths.
package capture_ring_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    DONE,
    READ
  } state_t;

  localparam int SIM_ENTRIES = 384;
  localparam int SIM_LOG2    = 9;
  localparam int DE0_ENTRIES = 12288;
  localparam int DE0_LOG2    = 14;

  // Depth is not a power of two, so pointers wrap explicitly at entries-1.
  function automatic int wrap_inc(input int ptr, input int entries);
    return (ptr >= entries - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/capture_ring_buffer_ring_ram_dp.sv
// Simple dual-port sample RAM: one write port, one read port whose data
// appears on the clock edge after the read is issued.
module ring_ram_dp #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 384,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: storage has no reset so it maps onto block RAM; only the control
  // path around it is reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/capture_ring_buffer.sv
// Pre/post-trigger capture into a circular RAM, frozen on completion and then
// streamed out oldest-first over valid/ready with a prefetching 2-entry skid.
module capture_ring_buffer
  import capture_ring_buffer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int ENTRIES  = SIM_ENTRIES,
  parameter int LOG2     = SIM_LOG2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic [LOG2-1:0]            trig_pos,
  input  logic                       smpl_vld,
  input  logic [CHANNELS*DATA_W-1:0] smpl_data,
  input  logic                       trig,
  output logic                       capture_done,
  output logic [LOG2-1:0]            trig_addr,
  input  logic                       rd_start,
  output logic                       rd_vld,
  output logic [CHANNELS*DATA_W-1:0] rd_data,
  output logic                       rd_last,
  input  logic                       rd_rdy,
  output logic                       busy
);

  localparam int W  = CHANNELS * DATA_W;
  localparam int CW = LOG2 + 1;
  localparam logic [CW-1:0] FULL = CW'(ENTRIES);

  state_t          r_state;
  logic [LOG2-1:0] r_wr_ptr, r_rd_ptr, r_post, r_post_cnt, r_trig_addr;
  logic [CW-1:0]   r_fill_cnt, r_pre, r_rd_cnt;
  logic            r_capture_done, r_busy;

  logic            r_ram_vld, r_ram_last;
  logic            r_rd_vld, r_rd_last, r_sk_vld, r_sk_last;
  logic [W-1:0]    r_rd_data, r_sk_data;

  logic            w_wr_en, w_start, w_pop, w_room, w_rd_issue, w_rd_issue_last;
  logic [LOG2-1:0] w_post_clamp, w_wr_ptr_nxt, w_rd_ptr_nxt, w_post_cnt_nxt;
  logic [CW-1:0]   w_fill_nxt;
  logic [1:0]      w_occ;
  logic [W-1:0]    w_ram_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_post_clamp = trig_pos;
    if (trig_pos == '0)                w_post_clamp = LOG2'(1);
    else if (int'(trig_pos) >= ENTRIES) w_post_clamp = LOG2'(ENTRIES - 1);
  end

  assign w_wr_en        = smpl_vld && (r_state == FILL || r_state == ARMED || r_state == POST);
  assign w_start        = arm && (r_state == IDLE || r_state == DONE);
  assign w_wr_ptr_nxt   = LOG2'(wrap_inc(int'(r_wr_ptr), ENTRIES));
  assign w_rd_ptr_nxt   = LOG2'(wrap_inc(int'(r_rd_ptr), ENTRIES));
  assign w_fill_nxt     = (r_fill_cnt == FULL) ? r_fill_cnt : r_fill_cnt + CW'(1);
  assign w_post_cnt_nxt = r_post_cnt + LOG2'(1);

  // Reads are issued only while the output pair plus the in-flight RAM read
  // still leaves a free slot after this cycle's pop.
  assign w_pop           = r_rd_vld && rd_rdy;
  assign w_occ           = 2'(r_rd_vld) + 2'(r_sk_vld) + 2'(r_ram_vld);
  assign w_room          = (w_occ < 2'd2) || (w_occ == 2'd2 && w_pop);
  assign w_rd_issue      = (r_state == READ) && (r_rd_cnt != FULL) && w_room;
  assign w_rd_issue_last = (r_rd_cnt == CW'(ENTRIES - 1));

  ring_ram_dp #(
    .WIDTH (W),
    .DEPTH (ENTRIES),
    .AW    (LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (smpl_data),
    .i_re    (w_rd_issue),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_post         <= '0;
      r_post_cnt     <= '0;
      r_trig_addr    <= '0;
      r_fill_cnt     <= '0;
      r_pre          <= '0;
      r_rd_cnt       <= '0;
      r_capture_done <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr   <= w_wr_ptr_nxt;
        r_fill_cnt <= w_fill_nxt;
      end
      if (w_rd_issue) begin
        r_rd_ptr <= w_rd_ptr_nxt;
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end
      if (w_start) begin
        r_state        <= FILL;
        r_wr_ptr       <= '0;
        r_fill_cnt     <= '0;
        r_post_cnt     <= '0;
        r_post         <= w_post_clamp;
        r_pre          <= FULL - {1'b0, w_post_clamp};
        r_capture_done <= 1'b0;
        r_busy         <= 1'b1;
      end else begin
        case (r_state)
          FILL: if (w_wr_en && w_fill_nxt >= r_pre) r_state <= ARMED;
          ARMED: if (trig) begin
            r_trig_addr <= r_wr_ptr;
            r_post_cnt  <= smpl_vld ? LOG2'(1) : '0;
            if (smpl_vld && r_post == LOG2'(1)) begin
              r_state        <= DONE;
              r_capture_done <= 1'b1;
            end else begin
              r_state <= POST;
            end
          end
          POST: if (w_wr_en) begin
            r_post_cnt <= w_post_cnt_nxt;
            if (w_post_cnt_nxt == r_post) begin
              r_state        <= DONE;
              r_capture_done <= 1'b1;
            end
          end
          DONE: if (rd_start) begin
            r_state  <= READ;
            r_rd_ptr <= r_wr_ptr;
            r_rd_cnt <= '0;
          end
          READ: if (w_pop && r_rd_last) begin
            r_state        <= IDLE;
            r_capture_done <= 1'b0;
            r_busy         <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Output register backed by one skid slot that absorbs the prefetched word
  // when the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_vld  <= 1'b0;
      r_ram_last <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_sk_vld   <= 1'b0;
      r_sk_last  <= 1'b0;
      r_sk_data  <= '0;
    end else begin
      r_ram_vld  <= w_rd_issue;
      r_ram_last <= w_rd_issue_last;
      if (!r_rd_vld || w_pop) begin
        if (r_sk_vld) begin
          r_rd_vld  <= 1'b1;
          r_rd_data <= r_sk_data;
          r_rd_last <= r_sk_last;
          r_sk_vld  <= r_ram_vld;
          r_sk_data <= w_ram_q;
          r_sk_last <= r_ram_vld && r_ram_last;
        end else begin
          r_rd_vld  <= r_ram_vld;
          r_rd_last <= r_ram_vld && r_ram_last;
          if (r_ram_vld) r_rd_data <= w_ram_q;
        end
      end else if (r_ram_vld) begin
        r_sk_vld  <= 1'b1;
        r_sk_data <= w_ram_q;
        r_sk_last <= r_ram_last;
      end
    end
  end

  assign capture_done = r_capture_done;
  assign trig_addr    = r_trig_addr;
  assign busy         = r_busy;
  assign rd_vld       = r_rd_vld;
  assign rd_data      = r_rd_data;
  assign rd_last      = r_rd_last;

endmodule

// File: tb/tb_capture_ring_buffer.sv
// Bench for capture_ring_buffer: directed captures plus randomized ones, with
// expected windows derived from the history of samples the bench wrote.
module tb_capture_ring_buffer;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, arm, smpl_vld, trig, rd_start, rd_rdy;
  logic [3:0]  trig_pos;
  logic [15:0] smpl_data;
  logic        capture_done, rd_vld, rd_last, busy;
  logic [3:0]  trig_addr;
  logic [15:0] rd_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] wr_q[$];

  capture_ring_buffer #(
    .DATA_W(8), .CHANNELS(2), .ENTRIES(N), .LOG2(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .trig_pos     (trig_pos),
    .smpl_vld     (smpl_vld),
    .smpl_data    (smpl_data),
    .trig         (trig),
    .capture_done (capture_done),
    .trig_addr    (trig_addr),
    .rd_start     (rd_start),
    .rd_vld       (rd_vld),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .rd_rdy       (rd_rdy),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {~b, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one capture. t1/t2 are sample indices carrying trig; with t_novld
  // the trigger is instead raised in an empty cycle just before sample t1.
  task automatic capture(input int tp, input int base, input int t1, input int t2,
                         input bit t_novld, input int vld_mode, input bit with_rd_start);
    int post, pre, written, post_w, n, exp_taddr;
    bit trig_seen, done, novld_used, vld, tg;
    post = (tp == 0) ? 1 : ((tp >= N) ? N - 1 : tp);
    pre  = N - post;
    wr_q.delete();
    arm = 1'b1; trig_pos = 4'(tp); trig = 1'b1; rd_start = with_rd_start; smpl_vld = 1'b0;
    tick();
    arm = 1'b0; trig = 1'b0; rd_start = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_done_low", capture_done, 0);
    written = 0; post_w = 0; n = 0; exp_taddr = 0;
    trig_seen = 0; done = 0; novld_used = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      case (vld_mode)
        0:       vld = 1'b1;
        1:       vld = cyc[0];
        default: vld = 1'($urandom_range(0, 1));
      endcase
      tg = 1'b0;
      if (t_novld) begin
        if (!novld_used && n == t1) begin vld = 1'b0; tg = 1'b1; novld_used = 1'b1; end
      end else if (vld && (n == t1 || n == t2)) begin
        tg = 1'b1;
      end
      smpl_vld = vld; smpl_data = pack(base + n); trig = tg;
      // A trigger counts once at least `pre` samples are already stored.
      if (!trig_seen && tg && written >= pre) begin
        trig_seen = 1'b1;
        exp_taddr = written % N;
        post_w    = vld ? 1 : 0;
      end else if (trig_seen && vld) begin
        post_w++;
      end
      if (vld) begin
        wr_q.push_back(pack(base + n));
        written++;
        n++;
      end
      done = trig_seen && (post_w == post);
      tick();
      check("capture_done", capture_done, done);
    end
    smpl_vld = 1'b0; trig = 1'b0;
    if (done) check("trig_addr", trig_addr, exp_taddr);
    else      check("capture_timeout", capture_done, 1);
  endtask

  // Streams the frozen window; stop_k < N abandons the readout early.
  task automatic readout(input bit rnd, input int stop_k);
    logic [15:0] exp_q[N];
    logic [15:0] h_data;
    bit          hold, h_last, rdy;
    int          k, first_s, last_s, b;
    b = wr_q.size() - N;
    for (int i = 0; i < N; i++) exp_q[i] = (b + i >= 0) ? wr_q[b + i] : 16'h0;
    rd_start = 1'b1; smpl_vld = 1'b1; smpl_data = 16'hA55A;
    tick();
    rd_start = 1'b0;
    k = 0; hold = 1'b0; h_data = '0; h_last = 1'b0; first_s = 0; last_s = 0;
    for (int step = 0; step < 200 && k < stop_k; step++) begin
      arm = (step == 3);
      smpl_vld = 1'b1; smpl_data = 16'(step * 37 + 5);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_rdy = rdy;
      check("rd_capture_done", capture_done, 1);
      if (hold) begin
        check("hold_vld", rd_vld, 1);
        check("hold_data", rd_data, h_data);
        check("hold_last", rd_last, h_last);
      end
      if (rd_vld && rdy) begin
        check("rd_data", rd_data, exp_q[k]);
        check("rd_last", rd_last, k == N - 1);
        if (k == 0) first_s = step;
        last_s = step;
        k++;
      end
      hold = rd_vld && !rdy; h_data = rd_data; h_last = rd_last;
      tick();
    end
    arm = 1'b0; rd_rdy = 1'b0; smpl_vld = 1'b0;
    if (stop_k == N) begin
      check("rd_count", k, N);
      check("rd_end_vld", rd_vld, 0);
      check("rd_end_done", capture_done, 0);
      check("rd_end_busy", busy, 0);
      if (!rnd) check("rd_throughput", last_s - first_s, N - 1);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig_pos = '0; smpl_vld = 1'b0; smpl_data = '0;
    trig = 1'b0; rd_start = 1'b0; rd_rdy = 1'b0;
    #2;
    check("rst_done", capture_done, 0);
    check("rst_taddr", trig_addr, 0);
    check("rst_vld", rd_vld, 0);
    check("rst_data", rd_data, 0);
    check("rst_last", rd_last, 0);
    check("rst_busy", busy, 0);
    #10 rst = 1'b0;

    // Wrapped capture, trigger on sample 20, full-rate readout.
    capture(4, 0, 20, -1, 1'b0, 0, 1'b0);
    check("s1_taddr", trig_addr, 4);
    readout(1'b0, N);

    // Trigger during FILL ignored, second one in ARMED taken.
    capture(4, 0, 5, 12, 1'b0, 0, 1'b0);
    check("s2_taddr", trig_addr, 12);
    readout(1'b0, N);

    // Same wrapped capture with random backpressure.
    capture(4, 0, 20, -1, 1'b0, 0, 1'b0);
    readout(1'b1, N);

    // Gapped samples, trigger raised in an empty cycle.
    capture(4, 0, 14, -1, 1'b1, 1, 1'b0);
    readout(1'b1, N);

    // Clamp of 0 to 1, then reset in the middle of the readout.
    capture(0, 0, 15, -1, 1'b0, 0, 1'b0);
    check("s5_taddr", trig_addr, 15);
    readout(1'b0, 5);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_done", capture_done, 0);
    check("mid_rst_taddr", trig_addr, 0);
    check("mid_rst_vld", rd_vld, 0);
    check("mid_rst_data", rd_data, 0);
    check("mid_rst_last", rd_last, 0);
    check("mid_rst_busy", busy, 0);
    #2 rst = 1'b0;
    capture(7, 50, 30, -1, 1'b0, 0, 1'b0);
    readout(1'b0, N);

    // Re-arm from DONE (with a competing rd_start); new data replaces old.
    capture(4, 0, 20, -1, 1'b0, 0, 1'b0);
    capture(6, 200, 25, -1, 1'b0, 2, 1'b1);
    readout(1'b1, N);

    // Randomized captures.
    for (int r = 0; r < 4; r++) begin
      int tp, t1;
      tp = $urandom_range(0, 15);
      t1 = $urandom_range(0, 30);
      capture(tp, $urandom_range(0, 255), t1, t1 + 20, 1'b0, 2, 1'b0);
      readout(1'b1, N);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_ring_buffer.md
Name: capture_ring_buffer

Overview:
- Parametrised, multi-channel successor to the single-port sample queue.
- Captures a continuous sample stream into a circular RAM, with a pre-trigger and post-trigger window.
- Freezes the window on completion, then streams it out oldest-first over a valid/ready interface to the readout/UART side.
- Sits between the channel sample front-end and the command/readout logic.

Parameters:
- DATA_W, 8: bits per channel sample.
- CHANNELS, 3: channels stored side by side per entry; entry width is CHANNELS*DATA_W.
- ENTRIES, 384: buffer depth. Use 384 for simulation and 12288 for DE-0.
- LOG2, 9: address width; must satisfy 2^LOG2 >= ENTRIES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse that starts a capture.
- trig_pos  in  LOG2  number of post-trigger samples; latched on arm.
- smpl_vld  in  1  smpl_data is valid this cycle.
- smpl_data  in  CHANNELS*DATA_W  channel 0 in the LSBs.
- trig  in  1  trigger event, level-sampled each cycle.
- capture_done  out  1  high while the captured window is frozen.
- trig_addr  out  LOG2  RAM address of the trigger sample.
- rd_start  in  1  pulse that begins readout; accepted only in DONE.
- rd_vld  out  1  rd_data is valid.
- rd_data  out  CHANNELS*DATA_W  readout entry.
- rd_last  out  1  marks the final entry of the readout.
- rd_rdy  in  1  consumer accepts rd_data when rd_vld&rd_rdy.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; wr_ptr, fill_cnt, post_cnt and rd counters all 0.
  - All outputs 0: capture_done, trig_addr, rd_vld, rd_data, rd_last, busy.
  - RAM contents are not reset.
  - A reset mid-capture or mid-readout aborts the operation; the next arm starts clean.
- Latched trig_pos is clamped: 0 becomes 1, and values >= ENTRIES become ENTRIES-1. The pre-trigger requirement is PRE = ENTRIES - post.
- IDLE:
  - arm sends the block to FILL, clearing wr_ptr and fill_cnt.
  - trig, smpl_vld and rd_start are ignored.
- Write rule, common to FILL, ARMED and POST:
  - Each smpl_vld cycle writes mem[wr_ptr] <= smpl_data.
  - wr_ptr then increments, wrapping from ENTRIES-1 to 0 (not power-of-two wrap).
  - fill_cnt increments and saturates at ENTRIES.
- FILL:
  - Moves to ARMED in the cycle after fill_cnt reaches PRE.
  - trig is ignored in FILL.
- ARMED:
  - trig with smpl_vld: that sample is the trigger sample and counts as post sample 1. trig_addr <= wr_ptr and post_cnt <= 1.
  - trig without smpl_vld: trig_addr <= wr_ptr (the next sample's address) and post_cnt <= 0.
  - Either case moves to POST. If post==1 and the trigger sample was written, go directly to DONE.
- POST:
  - Each written sample increments post_cnt.
  - Once post_cnt reaches post, writing stops and the state becomes DONE on the next edge.
  - trig is ignored in POST.
- DONE:
  - capture_done=1; no writes occur.
  - The oldest entry is at wr_ptr (the buffer is full).
  - rd_start moves to READ with rd_ptr=wr_ptr and rd_cnt=0.
  - arm re-arms to FILL and drops capture_done.
  - rd_start and arm in the same cycle: arm wins.
- READ:
  - Streams exactly ENTRIES entries in order from rd_ptr, wrapping at ENTRIES-1.
  - RAM read is synchronous with 1-cycle latency. Use a prefetch plus a 2-entry output skid so full throughput (1 entry/cycle) is sustained while rd_rdy=1.
  - rd_data/rd_vld/rd_last hold stable while rd_vld&!rd_rdy.
  - rd_last=1 only with entry ENTRIES-1.
  - Once the last entry is accepted: state IDLE, capture_done=0, rd_vld=0 on the next cycle.
  - arm is ignored in READ; capture_done stays 1 during READ.
- Simultaneous events:
  - trig and arm in IDLE: arm is taken, trig ignored.
  - smpl_vld in DONE or READ: dropped.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, FILL, ARMED, POST, DONE, READ;
  - a wrap-increment function for ENTRIES-modulo pointers;
  - the simulation and DE-0 depth constants (384/9, 12288/14).
- One sub-module: ring_ram_dp.
  - Simple dual-port RAM: 1 write port and 1 registered read port.
  - Parametrised by width and depth; carries the synthesis translate_off model.

Test Plan:
All scenarios use ENTRIES=16, LOG2=4, CHANNELS=2, DATA_W=8, with smpl_data = {~n,n} for sample index n.
- Wrapped capture: arm, trig_pos=4, continuous samples, trig with sample 20 -> capture_done after sample 23; trig_addr=4; readout (rd_rdy=1) yields n=8..23 in 16 consecutive cycles; rd_last only on n=23.
- Early trigger ignored: trig_pos=4, trig with sample 5 (FILL) and again with sample 12 (ARMED) -> trig_addr=12; readout n=0..15, no wrap.
- Backpressure: same as the wrapped-capture scenario but rd_rdy random 50% -> exactly 16 accepted entries, in order, no duplicates; rd_data stable whenever rd_vld&!rd_rdy.
- smpl_vld gaps: smpl_vld toggling every other cycle during POST, trig without smpl_vld -> exactly 4 post samples counted; done after the 4th valid sample.
- Clamp and restart: trig_pos=0 -> done on the trigger sample itself. Then rst asserted mid-READ -> all outputs 0 immediately; a fresh arm completes a normal capture.
- Arm in DONE: arm instead of rd_start -> capture_done drops next cycle; the new capture overwrites; readout reflects only the new data.
